// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the in-order pipeline front end:
//   - NOP_INSTR      : canonical bubble instruction (addi x0,x0,0)
//   - *_LSB          : bit positions of the RV32I instruction fields
//   - OPC_*          : RV32I major opcode constants
//   - fetch_state_e  : instruction-fetch FSM states
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int OPCODE_LSB = 0;
   localparam int RD_LSB     = 7;
   localparam int FUNCT3_LSB = 12;
   localparam int RS1_LSB    = 15;
   localparam int RS2_LSB    = 20;
   localparam int FUNCT7_LSB = 25;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      FULL = 2'd2,
      DROP = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/if_stage_fetch_buf.sv
// ---------------------------------------------------------------------------
// fetch_buf
// Single-entry hold buffer that parks a fetched word (and its PC) when the
// decode stage is stalled at the moment the memory response arrives.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   load            : capture in_data/in_pc, mark valid
//   clear           : drop the entry (highest priority)
//   pop             : entry consumed, mark invalid
//   in_data, in_pc  : word and PC to capture
//   data, pc, valid : stored entry
// ---------------------------------------------------------------------------
module fetch_buf
   import cpu_pkg::*;
#(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               clear,
   input  logic               pop,
   input  logic [D_WIDTH-1:0] in_data,
   input  logic [A_WIDTH-1:0] in_pc,
   output logic [D_WIDTH-1:0] data,
   output logic [A_WIDTH-1:0] pc,
   output logic               valid
);

   // Clear wins over load so a redirect in the same cycle as a late response
   // can never leave a stale instruction behind.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         data  <= D_WIDTH'(NOP_INSTR);
         pc    <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= in_data;
         pc    <= in_pc;
      end else if (pop) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: owns the PC, issues single-outstanding requests
// over a req/gnt/rvalid handshake, registers the returned word into IF/ID and
// splits it into decode fields. Handles decode stalls (en) and redirects.
// Optional feature macro: IF_STAGE_PERF_EN (adds fetch_cnt / stall_cnt).
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   en                      : decode ready (0 = hold IF/ID)
//   redirect, redirect_pc   : taken branch/jump and its target
//   imem_req/addr/gnt       : request side of instruction memory
//   imem_rvalid/rdata       : response side of instruction memory
//   instr, pc_id, valid_id  : IF/ID register
//   opcode..funct7          : fields of instr
//   fetch_cnt, stall_cnt    : performance counters (IF_STAGE_PERF_EN only)
// ---------------------------------------------------------------------------
module if_stage
   import cpu_pkg::*;
#(
   parameter int               D_WIDTH  = 32,
   parameter int               A_WIDTH  = 32,
   parameter int               RF_SIZE  = 5,
   parameter logic [A_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               redirect,
   input  logic [A_WIDTH-1:0] redirect_pc,
   output logic               imem_req,
   output logic [A_WIDTH-1:0] imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [D_WIDTH-1:0] imem_rdata,
   output logic [D_WIDTH-1:0] instr,
   output logic [6:0]         opcode,
   output logic [RF_SIZE-1:0] rd,
   output logic [2:0]         funct3,
   output logic [RF_SIZE-1:0] rs1,
   output logic [RF_SIZE-1:0] rs2,
   output logic [6:0]         funct7,
   output logic [A_WIDTH-1:0] pc_id,
   output logic               valid_id
`ifdef IF_STAGE_PERF_EN
   ,
   output logic [31:0]        fetch_cnt,
   output logic [31:0]        stall_cnt
`endif
);

   fetch_state_e       state, state_next;
   logic               run;
   logic [A_WIDTH-1:0] pc, pc_next;
   logic [A_WIDTH-1:0] pend_pc, pend_pc_next;
   logic               load_mem, load_buf, bubble;
   logic               buf_load, buf_clear, buf_pop;
   logic [D_WIDTH-1:0] buf_data;
   logic [A_WIDTH-1:0] buf_pc;
   logic               buf_valid;

   // The state register resets to REQ, but requests are held off until the
   // first edge after reset release so imem_req is low throughout reset.
   assign imem_req  = run && (state == REQ);
   assign imem_addr = pc;

   // State, PC and the PC of the in-flight request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= REQ;
         run     <= 1'b0;
         pc      <= RESET_PC;
         pend_pc <= RESET_PC;
      end else begin
         state   <= state_next;
         run     <= 1'b1;
         pc      <= pc_next;
         pend_pc <= pend_pc_next;
      end
   end

   // Next-state and datapath control. A redirect overrides everything else;
   // it goes to DROP only when a response is still owed, so the next request
   // cannot overlap the abandoned one. A response landing in the very cycle
   // of the redirect is consumed (and discarded) immediately.
   always_comb begin
      state_next   = state;
      pc_next      = pc;
      pend_pc_next = pend_pc;
      load_mem     = 1'b0;
      load_buf     = 1'b0;
      bubble       = 1'b0;
      buf_load     = 1'b0;
      buf_clear    = 1'b0;
      buf_pop      = 1'b0;

      if (redirect) begin
         pc_next   = redirect_pc & ~A_WIDTH'(3);
         bubble    = 1'b1;
         buf_clear = 1'b1;
         if (((state == WAIT) && !imem_rvalid) ||
             ((state == DROP) && !imem_rvalid) ||
             (imem_req && imem_gnt))
            state_next = DROP;
         else
            state_next = REQ;
      end else begin
         case (state)
            REQ: begin
               bubble = en;
               if (imem_req && imem_gnt) begin
                  pend_pc_next = pc;
                  pc_next      = pc + A_WIDTH'(4);
                  state_next   = WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  if (en) begin
                     load_mem   = 1'b1;
                     state_next = REQ;
                  end else begin
                     buf_load   = 1'b1;
                     state_next = FULL;
                  end
               end else begin
                  bubble = en;
               end
            end
            FULL: begin
               if (en && buf_valid) begin
                  load_buf   = 1'b1;
                  buf_pop    = 1'b1;
                  state_next = REQ;
               end
            end
            DROP: begin
               bubble = en;
               if (imem_rvalid)
                  state_next = REQ;
            end
            default: state_next = REQ;
         endcase
      end
   end

   fetch_buf #(
      .D_WIDTH (D_WIDTH),
      .A_WIDTH (A_WIDTH)
   ) u_fetch_buf (
      .clk     (clk),
      .rst     (rst),
      .load    (buf_load),
      .clear   (buf_clear),
      .pop     (buf_pop),
      .in_data (imem_rdata),
      .in_pc   (pend_pc),
      .data    (buf_data),
      .pc      (buf_pc),
      .valid   (buf_valid)
   );

   // IF/ID register. A bubble replaces the instruction with NOP but keeps the
   // last pc_id; with no load and no bubble (en=0) everything holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr    <= D_WIDTH'(NOP_INSTR);
         pc_id    <= '0;
         valid_id <= 1'b0;
      end else if (load_mem) begin
         instr    <= imem_rdata;
         pc_id    <= pend_pc;
         valid_id <= 1'b1;
      end else if (load_buf) begin
         instr    <= buf_data;
         pc_id    <= buf_pc;
         valid_id <= 1'b1;
      end else if (bubble) begin
         instr    <= D_WIDTH'(NOP_INSTR);
         valid_id <= 1'b0;
      end
   end

   assign opcode = instr[OPCODE_LSB +: 7];
   assign rd     = instr[RD_LSB     +: RF_SIZE];
   assign funct3 = instr[FUNCT3_LSB +: 3];
   assign rs1    = instr[RS1_LSB    +: RF_SIZE];
   assign rs2    = instr[RS2_LSB    +: RF_SIZE];
   assign funct7 = instr[FUNCT7_LSB +: 7];

`ifdef IF_STAGE_PERF_EN
   // Counts real instructions handed to decode, and cycles a real
   // instruction sat in IF/ID because decode was not ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (load_mem || load_buf)
            fetch_cnt <= fetch_cnt + 32'd1;
         if (valid_id && !en)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage. Inputs change just after each falling edge and
// outputs are sampled at falling edges. Expected IF/ID contents are queued
// when the memory response is driven and popped when decode should see them.
// Define IF_STAGE_PERF_EN to also exercise the performance counters.
// ---------------------------------------------------------------------------
module tb_if_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] pc_id;
   logic        valid_id;
`ifdef IF_STAGE_PERF_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
`endif

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   if_stage #(
      .D_WIDTH  (32),
      .A_WIDTH  (32),
      .RF_SIZE  (5),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .opcode      (opcode),
      .rd          (rd),
      .funct3      (funct3),
      .rs1         (rs1),
      .rs2         (rs2),
      .funct7      (funct7),
      .pc_id       (pc_id),
      .valid_id    (valid_id)
`ifdef IF_STAGE_PERF_EN
      ,
      .fetch_cnt   (fetch_cnt),
      .stall_cnt   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, then wait for the next falling edge.
   task automatic applyStimulus(input logic e, input logic r, input logic [31:0] rp,
                                input logic g, input logic rv, input logic [31:0] rdat);
      en          = e;
      redirect    = r;
      redirect_pc = rp;
      imem_gnt    = g;
      imem_rvalid = rv;
      imem_rdata  = rdat;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare IF/ID against the oldest queued expectation.
   task automatic popCheck(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("[TB] FAIL %s_sb_empty observed=0 expected=1", tag);
      end else begin
         e = sb.pop_front();
         checkOutput({tag, "_valid"}, 32'(valid_id), 32'd1);
         checkOutput({tag, "_instr"}, instr, e.word);
         checkOutput({tag, "_pc_id"}, pc_id, e.pc);
      end
   endtask

   initial begin
      rst         = 1'b0;
      en          = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      repeat (2) @(negedge clk);

      // Reset state
      checkOutput("rst_req",    32'(imem_req), 32'd0);
      checkOutput("rst_addr",   imem_addr, 32'h0);
      checkOutput("rst_instr",  instr, NOP_INSTR);
      checkOutput("rst_valid",  32'(valid_id), 32'd0);
      checkOutput("rst_pc_id",  pc_id, 32'h0);
      checkOutput("rst_opcode", 32'(opcode), 32'h13);

      rst = 1'b1;
      @(negedge clk);
      checkOutput("first_req",  32'(imem_req), 32'd1);
      checkOutput("first_addr", imem_addr, 32'h0);

      // Immediate grant, response next cycle
      applyStimulus(1, 0, 0, 1, 0, 0);
      checkOutput("t1_wait_req", 32'(imem_req), 32'd0);
      sb.push_back('{word: 32'h0050_0093, pc: 32'h0});
      applyStimulus(1, 0, 0, 0, 1, 32'h0050_0093);
      popCheck("t1");
      checkOutput("t1_opcode", 32'(opcode), 32'h13);
      checkOutput("t1_rd",     32'(rd), 32'd1);
      checkOutput("t1_rs1",    32'(rs1), 32'd0);
      checkOutput("t1_imm",    32'(rs2), 32'd5);
      checkOutput("t1_next_req",  32'(imem_req), 32'd1);
      checkOutput("t1_next_addr", imem_addr, 32'h4);

      // Decode stalled when the response arrives: word parks in the buffer
      applyStimulus(1, 0, 0, 1, 0, 0);
      checkOutput("t2_bubble", 32'(valid_id), 32'd0);
      sb.push_back('{word: 32'h0020_8113, pc: 32'h4});
      applyStimulus(0, 0, 0, 0, 1, 32'h0020_8113);
      checkOutput("t2_full_req",   32'(imem_req), 32'd0);
      checkOutput("t2_full_valid", 32'(valid_id), 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("t2_full_hold_req", 32'(imem_req), 32'd0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      popCheck("t2");
      checkOutput("t2_rd",   32'(rd), 32'd2);
      checkOutput("t2_rs1",  32'(rs1), 32'd1);
      checkOutput("t2_addr", imem_addr, 32'h8);

      // Redirect while a response is outstanding
      applyStimulus(1, 0, 0, 1, 0, 0);
      applyStimulus(1, 1, 32'h100, 0, 0, 0);
      checkOutput("t3_drop_valid", 32'(valid_id), 32'd0);
      checkOutput("t3_drop_req",   32'(imem_req), 32'd0);
      applyStimulus(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
      checkOutput("t3_discard_valid", 32'(valid_id), 32'd0);
      checkOutput("t3_discard_instr", instr, NOP_INSTR);
      checkOutput("t3_req",  32'(imem_req), 32'd1);
      checkOutput("t3_addr", imem_addr, 32'h100);

      // Grant withheld for 5 cycles
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 0, 0, 0, 0);
         checkOutput("t4_stall_req",  32'(imem_req), 32'd1);
         checkOutput("t4_stall_addr", imem_addr, 32'h100);
      end
      applyStimulus(1, 0, 0, 1, 0, 0);
      sb.push_back('{word: 32'h0030_8193, pc: 32'h100});
      applyStimulus(1, 0, 0, 0, 1, 32'h0030_8193);
      popCheck("t4");
      checkOutput("t4_next_addr", imem_addr, 32'h104);

      // Redirect to the top of the address space (low bits ignored), then wrap
      applyStimulus(1, 1, 32'hFFFF_FFFE, 0, 0, 0);
      checkOutput("t5_addr",  imem_addr, 32'hFFFF_FFFC);
      checkOutput("t5_req",   32'(imem_req), 32'd1);
      checkOutput("t5_valid", 32'(valid_id), 32'd0);
      applyStimulus(1, 0, 0, 1, 0, 0);
      sb.push_back('{word: 32'h0041_0213, pc: 32'hFFFF_FFFC});
      applyStimulus(1, 0, 0, 0, 1, 32'h0041_0213);
      popCheck("t5");
      checkOutput("t5_wrap_addr", imem_addr, 32'h0);

      // Decode stalled with a real instruction in IF/ID
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         checkOutput("stall_valid", 32'(valid_id), 32'd1);
         checkOutput("stall_instr", instr, 32'h0041_0213);
         checkOutput("stall_pc_id", pc_id, 32'hFFFF_FFFC);
      end
`ifdef IF_STAGE_PERF_EN
      checkOutput("perf_fetch_cnt", fetch_cnt, 32'd4);
      checkOutput("perf_stall_cnt", stall_cnt, 32'd3);
`endif

      // Redirect in the same cycle as a grant: that response must be dropped
      applyStimulus(1, 1, 32'h200, 1, 0, 0);
      checkOutput("t6_drop_req",   32'(imem_req), 32'd0);
      checkOutput("t6_drop_valid", 32'(valid_id), 32'd0);
      applyStimulus(1, 0, 0, 0, 1, 32'h1234_5678);
      checkOutput("t6_req",   32'(imem_req), 32'd1);
      checkOutput("t6_addr",  imem_addr, 32'h200);
      checkOutput("t6_valid", 32'(valid_id), 32'd0);

      // Stray response while requesting is ignored
      applyStimulus(1, 0, 0, 0, 1, 32'hCAFE_F00D);
      checkOutput("t7_req",   32'(imem_req), 32'd1);
      checkOutput("t7_addr",  imem_addr, 32'h200);
      checkOutput("t7_valid", 32'(valid_id), 32'd0);
      checkOutput("t7_instr", instr, NOP_INSTR);

      // Reset in the middle of a transaction
      applyStimulus(1, 0, 0, 1, 0, 0);
      rst         = 1'b0;
      imem_gnt    = 1'b0;
      #1;
      checkOutput("t8_req",   32'(imem_req), 32'd0);
      checkOutput("t8_addr",  imem_addr, 32'h0);
      checkOutput("t8_valid", 32'(valid_id), 32'd0);
      checkOutput("t8_instr", instr, NOP_INSTR);
      checkOutput("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
